number_display: RTL and testbench
=================================

# number_display

Memory-mapped seven-segment display peripheral at the IO end of the CPU's load/store path. It responds to the `NumberCtrl` chip select, which the CPU address decoder asserts at 0xFFFF_F020, and latches 32-bit store data as eight hex digits. It time-multiplexes the digits onto an 8-digit common-anode display and returns the low 16 bits of the latched value on IO reads.

## Interface
- `SCAN_DIV`, 100000: clock cycles each digit stays lit; must be ≥1.
- `LZ_BLANK`, 0: 1 enables leading-zero blanking.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous and active-high.
- `ioWrite`  in  1  IO write enable from the CPU.
- `ioRead`  in  1  IO read enable from the CPU.
- `NumberCtrl`  in  1  chip select for this device.
- `write_data`  in  32  store data from the CPU.
- `io_rdata`  out  16  readback data to the CPU.
- `seg_an`  out  8  digit anodes, active-low; bit i selects digit i, and digit 0 is the rightmost.
- `seg_out`  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.

## Operation
- Registers:
  - `shadow[31:0]`: CPU-visible value.
  - `active[31:0]`: value currently being displayed.
  - `presc`: counter, 0..SCAN_DIV-1.
  - `idx[2:0]`: current digit.
- Write: when `ioWrite & NumberCtrl` is high at a rising edge, `shadow <= write_data`. A write with `ioWrite` high and `NumberCtrl` low is ignored.
- Read: `io_rdata = shadow[15:0]` when `ioRead & NumberCtrl`, else 16'h0000. This path is combinational.
- Scan:
  - `presc` increments every cycle and wraps at SCAN_DIV-1.
  - On wrap, `idx <= idx+1` mod 8.
  - On the cycle `idx` goes 7→0, `active <= shadow`. This is the frame boundary, so a frame never shows a mix of old and new digits.
- Drive:
  - `seg_an = ~(8'b1 << idx)`.
  - `seg_out = {1'b1, hex7(active[4*idx +: 4])}`; the decimal point is always off.
  - Both outputs are combinational from the registers.
- hex7 uses gfedcba active-low codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E (values include dp=1).
- Blanking (LZ_BLANK=1):
  - Digit i is blanked when all nibbles i..7 of `active` are 0 and i≠0.
  - Blanked means `seg_an` stays 8'hFF for that slot and `seg_out` = 8'hFF.
  - Digit 0 is never blanked.

## Timing
- Reset values:
  - `shadow=0`, `active=0`, `presc=0`, `idx=0`.
  - `seg_an=8'hFE`, `seg_out=8'hC0`, `io_rdata=16'h0000`.
- Readback latency: a write at edge N is visible on `io_rdata` from cycle N+1.
- Display latency: a write appears on the display at the next 7→0 frame boundary. The maximum is 8·SCAN_DIV cycles.
- Write on the same edge as a frame boundary: `active` takes the pre-write `shadow`. The new value appears one frame later.
- Back-to-back writes within one frame: only the last one is displayed.
- SCAN_DIV=1: `idx` advances every cycle and `presc` stays 0.
- Reset asserted mid-frame: all registers return to their reset values on that edge, and scanning restarts at digit 0 after release.
- Read and write asserted together: `io_rdata` shows the old `shadow` in that cycle.

## Structure
- Shared `io_pkg` holds:
  - IO addresses (LED F000, Switch F010, Number F020).
  - Digit count (8).
  - The hex7 code constants and blank code 8'hFF.
- Sub-module `hex_to_seg7` (4-bit in, 7-bit active-low out) is purely combinational. It is reusable by other IO devices.

## Test plan
- Reset with SCAN_DIV=4: `seg_an=FE`, `seg_out=C0`; `seg_an` steps through FD, FB, … 7F every 4 cycles, then back to FE.
- Write 0x1234_ABCD with NumberCtrl high: `io_rdata` reads 0xABCD on the next cycle. After the frame boundary, the digits show D,C,B,A,4,3,2,1 with codes A1,C6,83,88,99,B0,A4,F9.
- Write with NumberCtrl low, value 0xFFFF_FFFF: `shadow` is unchanged and the display still shows the prior value.
- Write coincident with the 7→0 transition: the old value is shown for one full frame, then the new value.
- LZ_BLANK=1, write 0x0000_0050: digits 2–7 are blank (anode stays FF for those slots), digit 1 shows 5 (92), digit 0 shows 0 (C0).
- Assert rst mid-scan at idx=5: the next cycle has `idx=0`, `seg_an=FE`, `io_rdata=0`, and the display shows 0.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped IO devices: addresses, display geometry and
// active-low seven-segment codes.
package io_pkg;

  localparam logic [31:0] LedAddr    = 32'hFFFF_F000;
  localparam logic [31:0] SwitchAddr = 32'hFFFF_F010;
  localparam logic [31:0] NumberAddr = 32'hFFFF_F020;

  localparam int unsigned NumDigits = 8;

  // {dp,g,f,e,d,c,b,a}, active-low, dp off; entry n is the glyph for hex digit n.
  localparam logic [15:0][7:0] Hex7Codes = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  localparam logic [7:0] SegBlank = 8'hFF;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low gfedcba segment decoder.
module hex_to_seg7
  import io_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  logic [7:0] code;

  assign code = Hex7Codes[hex];
  assign seg  = code[6:0];

endmodule

// File: rtl/number_display.sv
// Eight-digit multiplexed hex display: CPU writes a shadow word, which is copied to the
// displayed word only at frame boundaries so a frame never mixes old and new digits.
module number_display
  import io_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000,
  parameter bit          LZ_BLANK = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ioWrite,
  input  logic        ioRead,
  input  logic        NumberCtrl,
  input  logic [31:0] write_data,
  output logic [15:0] io_rdata,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_out
);

  localparam int unsigned PrescW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(SCAN_DIV - 1);

  logic [31:0]       shadow_q;
  logic [31:0]       active_q;
  logic [PrescW-1:0] presc_q;
  logic [2:0]        idx_q;
  logic              wrap;

  assign wrap = (presc_q == PrescMax);

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
      presc_q  <= '0;
      idx_q    <= '0;
    end else begin
      if (ioWrite && NumberCtrl) begin
        shadow_q <= write_data;
      end
      presc_q <= wrap ? '0 : presc_q + 1'b1;
      if (wrap) begin
        idx_q <= idx_q + 3'd1;
        // Non-blocking read of shadow_q: a write on this same edge waits one more frame.
        if (idx_q == 3'd7) begin
          active_q <= shadow_q;
        end
      end
    end
  end

  logic [3:0] nibble;
  logic [6:0] seg7;
  logic       blank;

  assign nibble = active_q[{idx_q, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .hex (nibble),
    .seg (seg7)
  );

  // Blank when this digit and every more-significant digit are zero; digit 0 always shows.
  assign blank = LZ_BLANK && (idx_q != 3'd0) && ((active_q >> {idx_q, 2'b00}) == 32'd0);

  assign seg_an   = blank ? 8'hFF : ~(8'h01 << idx_q);
  assign seg_out  = blank ? SegBlank : {1'b1, seg7};
  assign io_rdata = (ioRead && NumberCtrl) ? shadow_q[15:0] : 16'h0000;

endmodule

// File: tb/tb_number_display.sv
// Directed bench for number_display with SCAN_DIV=4; a second instance covers blanking.
module tb_number_display;

  logic        clk = 1'b0;
  logic        rst;
  logic        ioWrite;
  logic        ioRead;
  logic        NumberCtrl;
  logic [31:0] write_data;
  logic [15:0] io_rdata, io_rdata_lz;
  logic [7:0]  seg_an, seg_out, seg_an_lz, seg_out_lz;

  always #5 clk = ~clk;

  number_display #(.SCAN_DIV(4), .LZ_BLANK(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .ioWrite    (ioWrite),
    .ioRead     (ioRead),
    .NumberCtrl (NumberCtrl),
    .write_data (write_data),
    .io_rdata   (io_rdata),
    .seg_an     (seg_an),
    .seg_out    (seg_out)
  );

  number_display #(.SCAN_DIV(4), .LZ_BLANK(1'b1)) dut_lz (
    .clk        (clk),
    .rst        (rst),
    .ioWrite    (ioWrite),
    .ioRead     (ioRead),
    .NumberCtrl (NumberCtrl),
    .write_data (write_data),
    .io_rdata   (io_rdata_lz),
    .seg_an     (seg_an_lz),
    .seg_out    (seg_out_lz)
  );

  typedef struct {
    string       tag;
    int          kind;  // 0: plain display, 1: blanking display, 2: readback
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 8'hC0;  4'h1: glyph = 8'hF9;  4'h2: glyph = 8'hA4;  4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;  4'h5: glyph = 8'h92;  4'h6: glyph = 8'h82;  4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;  4'h9: glyph = 8'h90;  4'hA: glyph = 8'h88;  4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;  4'hD: glyph = 8'hA1;  4'hE: glyph = 8'h86;  default: glyph = 8'h8E;
    endcase
  endfunction

  function automatic logic [15:0] digit(input int d, input logic [31:0] val);
    logic [7:0] an;
    logic [3:0] nib;
    an  = ~(8'h01 << d);
    nib = val[4*d +: 4];
    return {an, glyph(nib)};
  endfunction

  task automatic push(input string tag, input int kind, input logic [15:0] e);
    exp_t x;
    x.tag  = tag;
    x.kind = kind;
    x.exp  = e;
    sb.push_back(x);
  endtask

  task automatic check();
    exp_t        e;
    logic [15:0] obs;
    #1;
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty: observed nothing required an entry");
      return;
    end
    e = sb.pop_front();
    case (e.kind)
      0:       obs = {seg_an, seg_out};
      1:       obs = {seg_an_lz, seg_out_lz};
      default: obs = io_rdata;
    endcase
    assert (obs === e.exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h required %h", e.tag, obs, e.exp);
    end
  endtask

  task automatic expect_check(input string tag, input int kind, input logic [15:0] e);
    push(tag, kind, e);
    check();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  localparam logic [31:0] ValA = 32'h1234_ABCD;
  localparam logic [31:0] ValB = 32'h0000_0050;

  initial begin
    logic [7:0] an_exp;
    rst        = 1'b1;
    ioWrite    = 1'b0;
    ioRead     = 1'b0;
    NumberCtrl = 1'b0;
    write_data = '0;
    cycles(3);
    expect_check("reset_disp", 0, {8'hFE, 8'hC0});
    expect_check("reset_disp_lz", 1, {8'hFE, 8'hC0});
    ioRead     = 1'b1;
    NumberCtrl = 1'b1;
    expect_check("reset_rdata", 2, 16'h0000);
    rst = 1'b0;

    // One full frame of anode stepping, 4 cycles per digit.
    for (int k = 1; k <= 8; k++) begin
      cycles(4);
      an_exp = ~(8'h01 << (k % 8));
      expect_check($sformatf("scan_an_%0d", k % 8), 0, {an_exp, 8'hC0});
    end

    // t0: frame start. Write with a simultaneous read returns the old shadow.
    ioWrite    = 1'b1;
    write_data = ValA;
    expect_check("rd_during_wr", 2, 16'h0000);
    cycles(1);
    ioWrite = 1'b0;
    expect_check("rd_after_wr", 2, 16'hABCD);
    expect_check("disp_not_yet", 0, {8'hFE, 8'hC0});
    cycles(31);
    for (int d = 0; d < 8; d++) begin
      expect_check($sformatf("disp_a_d%0d", d), 0, digit(d, ValA));
      if (d < 7) cycles(4);
    end
    cycles(4);

    // t1: write ignored without chip select.
    NumberCtrl = 1'b0;
    ioWrite    = 1'b1;
    write_data = 32'hFFFF_FFFF;
    expect_check("rd_no_cs", 2, 16'h0000);
    cycles(1);
    ioWrite    = 1'b0;
    NumberCtrl = 1'b1;
    expect_check("rd_kept", 2, 16'hABCD);
    cycles(31);
    expect_check("disp_kept_d0", 0, digit(0, ValA));
    cycles(4);
    expect_check("disp_kept_d1", 0, digit(1, ValA));
    cycles(28);

    // t2: write lands on the edge of the 7->0 transition.
    cycles(31);
    ioWrite    = 1'b1;
    write_data = ValB;
    cycles(1);
    ioWrite = 1'b0;
    expect_check("coinc_old_d0", 0, digit(0, ValA));
    expect_check("coinc_rd", 2, 16'h0050);
    cycles(4);
    expect_check("coinc_old_d1", 0, digit(1, ValA));
    cycles(28);
    expect_check("coinc_new_d0", 0, digit(0, ValB));
    expect_check("lz_d0", 1, {8'hFE, 8'hC0});
    cycles(4);
    expect_check("coinc_new_d1", 0, digit(1, ValB));
    expect_check("lz_d1", 1, {8'hFD, 8'h92});
    cycles(4);
    expect_check("nolz_d2", 0, {8'hFB, 8'hC0});
    expect_check("lz_d2_blank", 1, {8'hFF, 8'hFF});
    cycles(12);
    expect_check("nolz_d5", 0, {8'hDF, 8'hC0});
    expect_check("lz_d5_blank", 1, {8'hFF, 8'hFF});

    // Reset in the middle of digit 5.
    rst = 1'b1;
    cycles(1);
    expect_check("midrst_disp", 0, {8'hFE, 8'hC0});
    expect_check("midrst_disp_lz", 1, {8'hFE, 8'hC0});
    expect_check("midrst_rdata", 2, 16'h0000);
    rst = 1'b0;
    cycles(4);
    expect_check("after_rst_d1", 0, {8'hFD, 8'hC0});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
